// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction control unit: fetch, decode, memory access and
// register write-back sequencing, with a bounded wait on the memory handshake.
module ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic [8:0]  operand_addr,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [1:0]  alu_op,
  output logic        reg_wr_en,
  output logic        reg_id,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [5:0] {
    OP_HLT   = 6'h00,
    OP_LOAD  = 6'h01,
    OP_STORE = 6'h02,
    OP_ADD   = 6'h03,
    OP_SUB   = 6'h04,
    OP_BRA   = 6'h05,
    OP_BRZ   = 6'h06,
    OP_NOP   = 6'h07
  } opcode_t;

  // Counter value seen on the last tolerated low-ready cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;
  logic [15:0]      ir;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       op;
  logic             ir_load;
  logic             set_illegal;
  logic             in_wait;
  logic             timeout_hit;

  assign op           = ir[15:10];
  assign operand_addr = ir[8:0];
  assign reg_id       = ir[9];
  assign in_wait      = (state == S_FETCH) || (state == S_MEM);
  assign timeout_hit  = (TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TO_LAST);

  // State register, instruction register, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      ir        <= '0;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load) ir <= mem_rdata;
      // Any cycle outside a wait state (or with ready high) leaves the counter
      // at zero, so entry into FETCH/MEM always starts from a clean count.
      if (in_wait && !mem_ready && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                       wait_cnt <= '0;
      if (set_illegal) illegal   <= 1'b1;
      if (timeout_hit) bus_error <= 1'b1;
    end
  end

  // Next-state and strobe decode from current state and IR.
  always_comb begin
    state_nx    = state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    addr_sel    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_op      = 2'b00;
    reg_wr_en   = 1'b0;
    halted      = 1'b0;
    ir_load     = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_INIT: state_nx = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout_hit) begin
          state_nx = S_HALT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_HLT: state_nx = S_HALT;
          OP_NOP: state_nx = S_FETCH;
          OP_BRA: begin
            pc_load  = 1'b1;
            state_nx = S_FETCH;
          end
          OP_BRZ: begin
            pc_load  = zero_flag;
            state_nx = S_FETCH;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_nx = S_MEM;
          default: begin
            set_illegal = 1'b1;
            state_nx    = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (op == OP_STORE) mem_wr = 1'b1;
        else                mem_rd = 1'b1;
        if (mem_ready)        state_nx = (op == OP_STORE) ? S_FETCH : S_WB;
        else if (timeout_hit) state_nx = S_HALT;
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        case (op)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        state_nx = S_FETCH;
      end
      S_HALT:  halted   = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

endmodule
